// File: rtl/bitcount_pkg.sv
// Shared types and default widths for the bit-count arbiter and its datapath.
package bitcount_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    RUN     = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam int DEF_N_REQ       = 4;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_RES_W       = $clog2(DEF_DATA_W + 1);
  localparam int DEF_TIMEOUT_CYC = 32;

endpackage

// File: rtl/rr_picker.sv
// Round-robin winner search: first set req bit starting just after last_grant.
module rr_picker #(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last_grant,
  output logic             any_req,
  output logic [ID_W-1:0]  winner
);

  logic [N_REQ-1:0]           hit;
  logic [N_REQ-1:0][ID_W-1:0] cand;

  // cand[k] is the requester k+1 places after last_grant, wrapped to N_REQ
  for (genvar k = 0; k < N_REQ; k++) begin : g_off
    assign cand[k] = ID_W'((int'(last_grant) + k + 1) % N_REQ);
    assign hit[k]  = req[cand[k]];
  end

  assign any_req = |req;

  // Scan from the farthest offset down so the nearest hit wins.
  always_comb begin
    winner = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (hit[k]) winner = cand[k];
    end
  end

endmodule

// File: rtl/bitcount_arbiter.sv
// Round-robin front end sharing one start/done bit-count datapath among N_REQ requesters.
module bitcount_arbiter
  import bitcount_pkg::*;
#(
  parameter  int N_REQ       = DEF_N_REQ,
  parameter  int DATA_W      = DEF_DATA_W,
  parameter  int RES_W       = $clog2(DATA_W + 1),
  parameter  int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  localparam int ID_W        = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic                    cnt_start,
  output logic [DATA_W-1:0]       cnt_data,
  input  logic [RES_W-1:0]        cnt_result,
  input  logic                    cnt_done,
  output logic                    busy,
  output logic [ID_W-1:0]         grant_id,
  output logic [N_REQ-1:0]        resp_valid,
  output logic [RES_W-1:0]        resp_count,
  output logic                    resp_err
);

  localparam int TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  state_t                         state;
  logic [ID_W-1:0]                last_grant;
  logic [ID_W-1:0]                winner;
  logic                           any_req;
  logic [TMO_W-1:0]               tmo_cnt;
  logic [N_REQ-1:0][DATA_W-1:0]   req_words;
  logic [N_REQ-1:0]               grant_oh;

  assign req_words = req_data;
  assign grant_oh  = N_REQ'(1) << grant_id;

  rr_picker #(.N_REQ(N_REQ)) u_pick (
    .req        (req),
    .last_grant (last_grant),
    .any_req    (any_req),
    .winner     (winner)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cnt_start  <= 1'b0;
      cnt_data   <= '0;
      busy       <= 1'b0;
      grant_id   <= '0;
      resp_valid <= '0;
      resp_count <= '0;
      resp_err   <= 1'b0;
      tmo_cnt    <= '0;
      last_grant <= ID_W'(N_REQ - 1);
    end else begin
      resp_valid <= '0;
      resp_err   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            grant_id <= winner;
            cnt_data <= req_words[winner];
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          // start is low this cycle so the datapath loads cnt_data
          tmo_cnt   <= '0;
          cnt_start <= 1'b1;
          state     <= RUN;
        end
        RUN: begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
          if (cnt_done) begin
            resp_count <= cnt_result;
            resp_valid <= grant_oh;
            cnt_start  <= 1'b0;
            state      <= RELEASE;
          end else if (tmo_cnt == TMO_LAST) begin
            resp_count <= '0;
            resp_valid <= grant_oh;
            resp_err   <= 1'b1;
            cnt_start  <= 1'b0;
            state      <= RELEASE;
          end
        end
        RELEASE: begin
          // a done stuck high parks us here; only busy reveals it
          if (!cnt_done) begin
            last_grant <= grant_id;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bitcount_arbiter.sv
// Scoreboard bench: round-robin service order and popcounts predicted from request sets.
module tb_bitcount_arbiter;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int RW  = 4;
  localparam int TMO = 32;
  localparam int IW  = 2;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic            cnt_start;
  logic [DW-1:0]   cnt_data;
  logic [RW-1:0]   cnt_result;
  logic            cnt_done;
  logic            busy;
  logic [IW-1:0]   grant_id;
  logic [N-1:0]    resp_valid;
  logic [RW-1:0]   resp_count;
  logic            resp_err;

  bitcount_arbiter #(.N_REQ(N), .DATA_W(DW), .RES_W(RW), .TIMEOUT_CYC(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_data   (req_data),
    .cnt_start  (cnt_start),
    .cnt_data   (cnt_data),
    .cnt_result (cnt_result),
    .cnt_done   (cnt_done),
    .busy       (busy),
    .grant_id   (grant_id),
    .resp_valid (resp_valid),
    .resp_count (resp_count),
    .resp_err   (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serial bit-count datapath stand-in: loads while start is low, shifts one bit per cycle.
  logic          dp_hang;
  logic [DW-1:0] dp_word;
  logic [RW-1:0] dp_acc;
  int            dp_k;
  always @(posedge clk) begin
    if (!reset) begin
      cnt_done <= 1'b0; cnt_result <= '0; dp_word <= '0; dp_acc <= '0; dp_k <= 0;
    end else if (!cnt_start) begin
      cnt_done <= 1'b0; dp_word <= cnt_data; dp_acc <= '0; dp_k <= 0;
    end else if (!cnt_done && !dp_hang) begin
      if (dp_k == DW) begin
        cnt_done <= 1'b1; cnt_result <= dp_acc;
      end else begin
        dp_acc  <= dp_acc + RW'(dp_word[0]);
        dp_word <= dp_word >> 1;
        dp_k    <= dp_k + 1;
      end
    end
  end

  typedef struct { int id; int cnt; bit err; } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int   n_chk, n_pass;
  int   m_last;
  int   rq_cnt[N];
  logic [DW-1:0] rq_data[N][4];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Monitor: every response pops the oldest expectation.
  always @(negedge clk) begin
    if (reset) begin
      if (resp_valid != '0) begin
        if (sb.size() == 0) chk("unexpected_resp", int'(resp_valid), 0);
        else begin
          mon_e = sb.pop_front();
          chk("resp_valid", int'(resp_valid), 1 << mon_e.id);
          chk("grant_id", int'(grant_id), mon_e.id);
          chk("resp_count", int'(resp_count), mon_e.cnt);
          chk("resp_err", int'(resp_err), int'(mon_e.err));
        end
      end else if (resp_err) chk("stray_err", int'(resp_err), 0);
    end
  end

  task automatic clr_round();
    for (int i = 0; i < N; i++) rq_cnt[i] = 0;
  endtask

  // Predict order from the requester multiset, then drive it; a requester keeps req up
  // across its response while it still has words queued.
  task automatic run_round(input bit err);
    int rem[N]; int ptr[N]; int served[N];
    int total, last, guard, lim;
    total = 0;
    for (int i = 0; i < N; i++) begin rem[i] = rq_cnt[i]; ptr[i] = 0; served[i] = 0; total += rq_cnt[i]; end
    last = m_last;
    for (int n = 0; n < total; n++) begin
      for (int off = 1; off <= N; off++) begin
        int j;
        j = (last + off) % N;
        if (rem[j] > 0) begin
          sb.push_back('{j, err ? 0 : $countones(rq_data[j][ptr[j]]), err});
          ptr[j]++; rem[j]--; last = j;
          break;
        end
      end
    end
    m_last = last;
    @(negedge clk);
    for (int i = 0; i < N; i++) if (rq_cnt[i] > 0) begin
      req[i] = 1'b1;
      req_data[i*DW +: DW] = rq_data[i][0];
    end
    lim = 60 * total + 100;
    guard = 0;
    while (req != '0 && guard < lim) begin
      @(negedge clk);
      guard++;
      for (int i = 0; i < N; i++) if (resp_valid[i] && req[i]) begin
        served[i]++;
        if (served[i] < rq_cnt[i]) req_data[i*DW +: DW] = rq_data[i][served[i]];
        else req[i] = 1'b0;
      end
    end
    if (req != '0) begin
      chk("round_timeout", int'(req), 0);
      req = '0;
      sb.delete();
    end
    guard = 0;
    while (busy && guard < 100) begin @(negedge clk); guard++; end
    if (busy) chk("busy_stuck", int'(busy), 0);
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (cnt_start) ok = 1'b1;
    end
    if (!ok) chk("start_seen", 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    n_chk = 0; n_pass = 0;
    reset = 1'b0; req = '0; req_data = '0; dp_hang = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cnt_start", int'(cnt_start), 0);
    chk("rst_cnt_data", int'(cnt_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_grant_id", int'(grant_id), 0);
    chk("rst_resp_valid", int'(resp_valid), 0);
    chk("rst_resp_count", int'(resp_count), 0);
    chk("rst_resp_err", int'(resp_err), 0);
    reset = 1'b1; m_last = N - 1;

    // Fairness: all held, requester 0 re-requests at its response -> 0,1,2,3,0
    clr_round();
    rq_cnt[0] = 2; rq_cnt[1] = 1; rq_cnt[2] = 1; rq_cnt[3] = 1;
    rq_data[0][0] = 8'hAA; rq_data[0][1] = 8'hAA; rq_data[1][0] = 8'h01;
    rq_data[2][0] = 8'h00; rq_data[3][0] = 8'hFF;
    run_round(1'b0);

    // Wrap: serve 2, then {0,2} must go 0 then 2
    clr_round(); rq_cnt[2] = 1; rq_data[2][0] = 8'h0F;
    run_round(1'b0);
    clr_round(); rq_cnt[0] = 1; rq_cnt[2] = 1; rq_data[0][0] = 8'h81; rq_data[2][0] = 8'h7F;
    run_round(1'b0);

    // Data change after grant is ignored
    clr_round(); rq_cnt[1] = 1; rq_data[1][0] = 8'h38;
    fork
      run_round(1'b0);
      begin
        wait_start(ok);
        req_data[1*DW +: DW] = 8'hFF;
      end
    join

    // Single request plus release timing
    clr_round(); rq_cnt[0] = 1; rq_data[0][0] = 8'hFF;
    fork
      run_round(1'b0);
      begin
        int g;
        g = 0;
        while (resp_valid == '0 && g < 100) begin @(negedge clk); g++; end
        @(negedge clk);
        chk("busy_in_release", int'(busy), 1);
        @(negedge clk);
        chk("busy_after_done_drop", int'(busy), 0);
      end
    join

    // Timeout: datapath never finishes
    dp_hang = 1'b1;
    clr_round(); rq_cnt[3] = 1; rq_data[3][0] = 8'h55;
    fork
      run_round(1'b1);
      begin
        int k;
        wait_start(ok);
        k = 0;
        while (ok && resp_valid == '0 && k < 200) begin @(negedge clk); k++; end
        chk("timeout_latency", k, TMO);
      end
    join
    dp_hang = 1'b0;

    // Reset mid-RUN aborts without a response
    @(negedge clk);
    req = 4'b0010; req_data[1*DW +: DW] = 8'hF0;
    wait_start(ok);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rstrun_cnt_start", int'(cnt_start), 0);
    chk("rstrun_busy", int'(busy), 0);
    chk("rstrun_resp_valid", int'(resp_valid), 0);
    req = '0; reset = 1'b1; m_last = N - 1;
    clr_round(); rq_cnt[1] = 1; rq_cnt[3] = 1; rq_cnt[0] = 1;
    rq_data[0][0] = 8'h03; rq_data[1][0] = 8'hE0; rq_data[3][0] = 8'h11;
    run_round(1'b0);

    // Randomized rounds
    for (int r = 0; r < 20; r++) begin
      int tot;
      clr_round();
      tot = 0;
      for (int i = 0; i < N; i++) begin
        rq_cnt[i] = int'($urandom_range(0, 2));
        tot += rq_cnt[i];
        for (int w = 0; w < 4; w++) rq_data[i][w] = DW'($urandom);
      end
      if (tot == 0) rq_cnt[int'($urandom_range(0, N - 1))] = 1;
      run_round(1'b0);
    end

    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
